// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state / mux select codes and the default payload width.
// The TX output multiplexer decodes the same codes, so they live only here.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned STATE_WIDTH        = 3;

  localparam logic [STATE_WIDTH-1:0] IDLE   = 3'd0;
  localparam logic [STATE_WIDTH-1:0] START  = 3'd1;
  localparam logic [STATE_WIDTH-1:0] DATA   = 3'd2;
  localparam logic [STATE_WIDTH-1:0] PARITY = 3'd3;
  localparam logic [STATE_WIDTH-1:0] STOP   = 3'd4;

  typedef enum logic [STATE_WIDTH-1:0] {
    StIdle   = IDLE,
    StStart  = START,
    StData   = DATA,
    StParity = PARITY,
    StStop   = STOP
  } tx_state_e;

endpackage

// File: rtl/uart_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// Presents the current bit LSB first and flags the final payload bit.
module uart_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_data,
  output logic                  last_bit
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CntW-1:0]       cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= data;
      cnt_q   <= '0;
    end else if (shift) begin
      shift_q <= shift_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign ser_data = shift_q[0];
  assign last_bit = (cnt_q == CntW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: accepts a byte, then walks START, DATA, optional PARITY
// and STOP at one state per bit period, driving the TX mux select directly from the state.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned STATEWIDTH = STATE_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [STATEWIDTH-1:0] mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  tx_state_e state_q;
  logic      par_en_q;
  logic      load;
  logic      shift;
  logic      last_bit;

  assign load  = (state_q == StIdle) && DATA_VALID;
  assign shift = (state_q == StData);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (DATA_VALID) begin
            state_q  <= StStart;
            busy     <= 1'b1;
            par_en_q <= PAR_EN;
            // Odd parity is the complement of the even (XOR) parity.
            par_bit  <= (^P_DATA) ^ PAR_TYP;
          end
        end
        StStart: state_q <= StData;
        StData: begin
          if (last_bit) begin
            state_q <= par_en_q ? StParity : StStop;
          end
        end
        StParity: state_q <= StStop;
        StStop: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mux_sel = STATEWIDTH'(state_q);

  uart_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .shift    (shift),
    .data     (P_DATA),
    .ser_data (ser_data),
    .last_bit (last_bit)
  );

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: directed scenarios plus random traffic against a frame-level model.
module tb_uart_tx_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] pd;
  logic       dv;
  logic       pe;
  logic       pt;
  logic [2:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fsm dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (pd),
    .DATA_VALID (dv),
    .PAR_EN     (pe),
    .PAR_TYP    (pt),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one entry per line cycle of the frame still to come.
  typedef struct packed {
    logic [2:0] mux;
    logic       sd;
    logic       chk_sd;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  logic exp_par;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d,
                            input logic e, input logic t);
    if (r) begin
      q.delete();
      cur     = '{mux: 3'd0, sd: 1'b0, chk_sd: 1'b1};
      exp_par = 1'b0;
    end else if (cur.mux == 3'd0 && v) begin
      exp_par = (^d) ^ t;
      q.delete();
      q.push_back('{mux: 3'd1, sd: 1'b0, chk_sd: 1'b0});
      for (int i = 0; i < 8; i++) q.push_back('{mux: 3'd2, sd: d[i], chk_sd: 1'b1});
      if (e) q.push_back('{mux: 3'd3, sd: 1'b0, chk_sd: 1'b0});
      q.push_back('{mux: 3'd4, sd: 1'b0, chk_sd: 1'b0});
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = '{mux: 3'd0, sd: 1'b0, chk_sd: 1'b0};
    end
  endtask

  // One bit period: drive, clock, update model, compare.
  task automatic run(input logic r, input logic v, input logic [7:0] d,
                     input logic e, input logic t);
    rst = r;
    dv  = v;
    pd  = d;
    pe  = e;
    pt  = t;
    @(posedge clk);
    model_edge(r, v, d, e, t);
    #1;
    check("mux_sel", 32'(mux_sel), 32'(cur.mux));
    check("busy", 32'(busy), 32'(cur.mux != 3'd0));
    check("par_bit", 32'(par_bit), 32'(exp_par));
    if (cur.chk_sd) check("ser_data", 32'(ser_data), 32'(cur.sd));
  endtask

  int         busy_cnt;
  int         par_cnt;
  int         starts;
  int         gap;
  logic [7:0] cap;
  logic [2:0] prev_mux;

  initial begin
    cur     = '{mux: 3'd0, sd: 1'b0, chk_sd: 1'b0};
    exp_par = 1'b0;
    run(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    run(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 0xA5 with even and then odd parity
    for (int t = 0; t < 2; t++) begin
      busy_cnt = 0;
      cap      = '0;
      run(1'b0, 1'b1, 8'hA5, 1'b1, 1'(t));
      busy_cnt += int'(busy);
      for (int c = 0; c < 14; c++) begin
        run(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        busy_cnt += int'(busy);
        if (mux_sel == 3'd2) cap = {ser_data, cap[7:1]};
      end
      check("a5_busy_len", 32'(busy_cnt), 32'd11);
      check("a5_bits", 32'(cap), 32'hA5);
      check("a5_par", 32'(par_bit), 32'(t));
    end

    // 0x00 without parity
    busy_cnt = 0;
    par_cnt  = 0;
    run(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    busy_cnt += int'(busy);
    for (int c = 0; c < 14; c++) begin
      run(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      busy_cnt += int'(busy);
      if (mux_sel == 3'd3) par_cnt++;
    end
    check("nopar_busy_len", 32'(busy_cnt), 32'd10);
    check("nopar_parity_visits", 32'(par_cnt), 32'd0);

    // 0x3C frame with a 0xFF request injected during DATA
    cap    = '0;
    starts = 0;
    run(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    if (mux_sel == 3'd1) starts++;
    for (int c = 0; c < 20; c++) begin
      if (c >= 3 && c <= 5) run(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
      else run(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
      if (mux_sel == 3'd2) cap = {ser_data, cap[7:1]};
      if (mux_sel == 3'd1) starts++;
    end
    check("ignore_bits", 32'(cap), 32'h3C);
    check("ignore_starts", 32'(starts), 32'd1);

    // DATA_VALID held: exactly one idle cycle between frames
    gap      = 0;
    starts   = 0;
    prev_mux = 3'd0;
    for (int c = 0; c < 40; c++) begin
      run(1'b0, 1'b1, 8'h81, 1'b1, 1'b0);
      if (mux_sel == 3'd0) gap++;
      if (mux_sel == 3'd1 && prev_mux == 3'd0) begin
        if (starts > 0) check("b2b_gap", 32'(gap), 32'd1);
        starts++;
      end
      if (mux_sel != 3'd0) gap = 0;
      prev_mux = mux_sel;
    end
    for (int c = 0; c < 14; c++) run(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset during the 4th data bit
    run(1'b0, 1'b1, 8'hF7, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) run(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_state", 32'(mux_sel), 32'd2);
    run(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_mux", 32'(mux_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ser", 32'(ser_data), 32'd0);
    check("rst_par", 32'(par_bit), 32'd0);
    for (int c = 0; c < 6; c++) run(1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      run(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0),
          8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame sequencer and serializer for the UART transmitter, one stage upstream of the TX output multiplexer. It accepts a parallel byte with a valid strobe and latches it together with the parity configuration. It then steps through START, DATA, optional PARITY and STOP, driving the multiplexer select, serial data bit and parity bit. The clock runs at the bit rate, so one clock cycle equals one bit period on the line.

## Interface
- DATA_WIDTH, 8, payload bits per frame.
- STATEWIDTH, 3, width of the state / mux select encoding.
- CLK  input  1  bit-rate clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only on accept.
- DATA_VALID  input  1  request to transmit P_DATA.
- PAR_EN  input  1  1 = insert parity bit; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- mux_sel  output  STATEWIDTH  current state code for the TX multiplexer.
- ser_data  output  1  current payload bit, LSB first.
- par_bit  output  1  parity of the latched payload.
- busy  output  1  high while a frame is on the line.

## Operation
- Reset is synchronous and active-high, and one clock is used throughout.
- State codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. Codes 5–7 are unreachable; if entered, the next state is IDLE.
- mux_sel is the registered state register itself, with no decode logic.
- IDLE
  - busy=0.
  - If DATA_VALID=1 at a rising edge: load the shift register with P_DATA, latch PAR_EN, latch PAR_TYP, compute par_bit, clear the bit counter, go to START.
- START: one cycle, then go to DATA.
- DATA
  - DATA_WIDTH cycles.
  - ser_data = shift_reg[0] throughout.
  - The shift register shifts right by one and the counter increments at each edge.
  - When counter == DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY: one cycle, then go to STOP.
- STOP: one cycle, then go to IDLE unconditionally. DATA_VALID is not accepted in STOP, so every frame is followed by at least one IDLE cycle.
- Parity
  - par_bit = XOR of the latched payload when PAR_TYP=0.
  - par_bit = XNOR of the latched payload when PAR_TYP=1.
  - Registered at accept and held until the next accept.
- Outside IDLE:
  - DATA_VALID is ignored.
  - P_DATA, PAR_EN and PAR_TYP changes have no effect on the current frame.
- Reset values: mux_sel=0 (IDLE), ser_data=0, par_bit=0, busy=0, shift register=0, counter=0.

## Timing
- Accept edge = edge k.
  - mux_sel=1 during cycle k+1.
  - First data bit during cycle k+2.
  - Last data bit during cycle k+1+DATA_WIDTH.
- Frame length on the line:
  - 1+DATA_WIDTH+1 cycles without parity (10 at default).
  - 1+DATA_WIDTH+2 cycles with parity (11 at default).
- busy
  - Registered; equals (state != IDLE).
  - Rises in the cycle after the accept edge.
  - Falls in the cycle after STOP.
- Back-to-back: with DATA_VALID held high, consecutive frames are separated by exactly one IDLE cycle.
- RST=1 at any edge, including mid-frame:
  - All outputs take their reset values in the following cycle.
  - The frame in progress is abandoned, not completed.
  - RST=1 takes priority over DATA_VALID.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package uart_pkg holds:
  - State codes IDLE..STOP as localparams of width STATEWIDTH.
  - The DATA_WIDTH default.
- The TX multiplexer and this block both use uart_pkg; the codes must not be redefined locally.
- One sub-module, uart_serializer, holds the shift register and bit counter.
  - Inputs: load, shift, data.
  - Outputs: ser_data, last_bit.
  - The FSM in uart_tx_fsm drives load and shift and consumes last_bit.
- Parity is a single reduction expression inside uart_tx_fsm, not a separate module.

## Test plan
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID pulse:
  - mux_sel sequence 1, 2×8, 3, 4, 0.
  - ser_data during DATA = 1,0,1,0,0,1,0,1.
  - par_bit=0; busy high for exactly 11 cycles.
- Same payload with PAR_TYP=1: par_bit=1; all else identical.
- P_DATA=0x00, PAR_EN=0:
  - mux_sel sequence 1, 2×8, 4, 0; PARITY never visited.
  - busy high for 10 cycles.
- Change P_DATA to 0xFF and pulse DATA_VALID during DATA of a 0x3C frame:
  - The frame completes with bits of 0x3C.
  - The pulse is ignored, and no second frame starts.
- DATA_VALID held high with P_DATA=0x81, PAR_EN=1: frames repeat with exactly one cycle of mux_sel=0 between STOP and START.
- Assert RST for one cycle at the 4th DATA bit: next cycle mux_sel=0, busy=0, ser_data=0, par_bit=0, and the FSM stays idle until the next DATA_VALID.
